stat_bist_ctrl: RTL and testbench

//   Built-in self-test sequencer for one combinational Stat_* benchmark netlist. On start it

---
 rtl/stat_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_stat_bist_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_bist_ctrl.sv
// -----------------------------------------------------------------------------
// stat_bist_ctrl
//   Built-in self-test sequencer for one combinational Stat_* benchmark netlist.
//   A run drives NUM_PATTERNS pseudo-random 28-bit vectors from an LFSR into the
//   netlist, compacts the 17 netlist outputs into a MISR signature and compares
//   the final signature to golden_sig.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   run request, sampled in IDLE only
//   abort        in   cancel the current run (back to IDLE, no done pulse)
//   golden_sig   in   expected final signature, stable while busy
//   dut_in       out  registered vector driven to netlist inputs n1..n28
//   dut_out      in   netlist outputs n389..n405
//   busy         out  high from LOAD through CAPTURE of the last vector
//   done         out  one-cycle pulse at end of run
//   pass         out  final signature matched golden_sig (sticky)
//   signature    out  current MISR contents
//   pattern_cnt  out  vectors captured so far in this run
//   state_dbg    out  current FSM state (IDLE=0, LOAD=1, APPLY=2, CAPTURE=3, DONE=4)
//
// Handshake: start is a level request that is only looked at while idle; the
// controller answers every accepted request with exactly one done pulse unless
// the run is aborted or reset. Requests while busy or in DONE are dropped.
// -----------------------------------------------------------------------------
module stat_bist_ctrl #(
    parameter int              IN_W          = 28,
    parameter int              OUT_W         = 17,
    parameter int              NUM_PATTERNS  = 1024,
    parameter int              SETTLE_CYCLES = 1,
    parameter logic [IN_W-1:0] LFSR_SEED     = 28'h0000001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pattern_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_APPLY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [IN_W-1:0] SEED_EFF =
        (LFSR_SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic [15:0] LAST_CNT    = 16'(NUM_PATTERNS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [3:0]       settle;
    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;

    // dut_in is the LFSR register itself: it only advances on CAPTURE, which
    // is exactly when the netlist should see the next vector.
    assign lfsr_next = {dut_in[26:0], dut_in[27] ^ dut_in[24]};
    assign misr_next = {signature[15:0], signature[16] ^ signature[13]} ^ dut_out;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            settle      <= '0;
            dut_in      <= '0;
            signature   <= '0;
            pattern_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // signature, pattern_cnt and dut_in keep their values for inspection.
                state  <= S_IDLE;
                settle <= '0;
                busy   <= 1'b0;
                pass   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // abort has priority over a simultaneous start.
                        if (start && !abort) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        dut_in      <= SEED_EFF;
                        signature   <= '0;
                        pattern_cnt <= '0;
                        settle      <= '0;
                        pass        <= 1'b0;
                        state       <= S_APPLY;
                    end
                    S_APPLY: begin
                        if (settle == SETTLE_LAST) begin
                            settle <= '0;
                            state  <= S_CAPTURE;
                        end else begin
                            settle <= settle + 4'd1;
                        end
                    end
                    S_CAPTURE: begin
                        signature   <= misr_next;
                        pattern_cnt <= pattern_cnt + 16'd1;
                        if (pattern_cnt == LAST_CNT) begin
                            // Last vector stays on dut_in after the run.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dut_in <= lfsr_next;
                            state  <= S_APPLY;
                        end
                    end
                    S_DONE: begin
                        pass  <= (signature == golden_sig);
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stat_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stat_bist_ctrl
//   Two controller instances share the clock and reset:
//     instance 0: 4 patterns, 1 settle cycle, seed 0 (runs from 1)
//     instance 1: 40 patterns, 2 settle cycles, seed with both tap bits set
//   Each run precomputes the vector list and the signature after every
//   capture, then checks every cycle against the cycle numbers implied by
//   the run timing (start sampled at cycle 0, LOAD at 1, vector i first
//   applied at 2+i*(S+1), done at 2+N*(S+1)).
// -----------------------------------------------------------------------------
module tb_stat_bist_ctrl;

    localparam int          N_A = 4;
    localparam int          S_A = 1;
    localparam logic [27:0] SEED_A = 28'h0000000;
    localparam int          N_B = 40;
    localparam int          S_B = 2;
    localparam logic [27:0] SEED_B = 28'h9000001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_v   [2];
    logic        abort_v   [2];
    logic [16:0] golden_v  [2];
    logic [16:0] dut_out_v [2];
    logic [27:0] dut_in_v  [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        pass_v    [2];
    logic [16:0] sig_v     [2];
    logic [15:0] cnt_v     [2];
    logic [2:0]  st_v      [2];
    int          mode_v    [2];
    logic [16:0] mask_v    [2];

    // Bench-side expectations of what each instance holds while idle.
    logic [15:0] exp_cnt_v  [2];
    logic        exp_pass_v [2];

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    function automatic logic [16:0] resp(input int mode, input logic [16:0] mask,
                                         input logic [27:0] din);
        if (mode == 0) return 17'd0;
        if (mode == 1) return din[16:0];
        return din[16:0] ^ din[27:11] ^ mask;
    endfunction

    function automatic logic [27:0] lfsr_step(input logic [27:0] v);
        return {v[26:0], v[27] ^ v[24]};
    endfunction

    function automatic logic [16:0] misr_step(input logic [16:0] m, input logic [16:0] r);
        return {m[15:0], m[16] ^ m[13]} ^ r;
    endfunction

    function automatic int n_of(input int k);
        return (k == 0) ? N_A : N_B;
    endfunction

    function automatic int s_of(input int k);
        return (k == 0) ? S_A : S_B;
    endfunction

    function automatic logic [27:0] seed_of(input int k);
        logic [27:0] s;
        s = (k == 0) ? SEED_A : SEED_B;
        return (s == 28'd0) ? 28'd1 : s;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- DUTs ----------------
    assign dut_out_v[0] = resp(mode_v[0], mask_v[0], dut_in_v[0]);
    assign dut_out_v[1] = resp(mode_v[1], mask_v[1], dut_in_v[1]);

    stat_bist_ctrl #(.NUM_PATTERNS(N_A), .SETTLE_CYCLES(S_A), .LFSR_SEED(SEED_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .golden_sig(golden_v[0]), .dut_in(dut_in_v[0]), .dut_out(dut_out_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]),
        .pattern_cnt(cnt_v[0]), .state_dbg(st_v[0])
    );

    stat_bist_ctrl #(.NUM_PATTERNS(N_B), .SETTLE_CYCLES(S_B), .LFSR_SEED(SEED_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .golden_sig(golden_v[1]), .dut_in(dut_in_v[1]), .dut_out(dut_out_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]),
        .pattern_cnt(cnt_v[1]), .state_dbg(st_v[1])
    );

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one run ----------------
    // gmode: 0 = use gval, 1 = model signature, 2 = model signature with bit 0 flipped
    // kill_kind: 0 = none, 1 = abort, 2 = reset, asserted during cycle kill_cyc
    // restart_cyc: cycle in which start is pulsed again (0 = never)
    task automatic run(input int k, input int gmode, input logic [16:0] gval,
                       input int kill_cyc, input int kill_kind, input int restart_cyc);
        logic [27:0] vecs[$];
        logic [16:0] sigs[$];
        logic [27:0] v;
        logic [16:0] gold;
        int n, s, done_cyc, last_cyc, done_cnt, c, kc;
        n = n_of(k);
        s = s_of(k);
        done_cyc = 2 + n * (s + 1);
        v = seed_of(k);
        sigs.push_back(17'd0);
        for (int i = 0; i < n; i++) begin
            vecs.push_back(v);
            sigs.push_back(misr_step(sigs[i], resp(mode_v[k], mask_v[k], v)));
            v = lfsr_step(v);
        end
        gold = (gmode == 0) ? gval : (gmode == 1) ? sigs[n] : (sigs[n] ^ 17'd1);
        golden_v[k] = gold;
        done_cnt = 0;
        last_cyc = (kill_kind != 0) ? kill_cyc + 4 : done_cyc + 3;
        kc = imin(n, (kill_cyc - 2) / (s + 1));

        @(negedge clk);
        start_v[k] = 1'b1;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[k] = (cyc == restart_cyc);
            abort_v[k] = (kill_kind == 1 && cyc == kill_cyc);
            rst_n      = !(kill_kind == 2 && cyc == kill_cyc);
            if (done_v[k]) done_cnt++;
            if (kill_kind != 0 && cyc > kill_cyc) begin
                chk("kill_busy", busy_v[k], 0);
                chk("kill_done", done_v[k], 0);
                chk("kill_pass", pass_v[k], 0);
                chk("kill_state", st_v[k], 0);
                if (kill_kind == 2) begin
                    chk("rst_cnt", cnt_v[k], 0);
                    chk("rst_sig", sig_v[k], 0);
                    chk("rst_din", dut_in_v[k], 0);
                end else begin
                    chk("abort_cnt", cnt_v[k], kc);
                    chk("abort_sig", sig_v[k], sigs[kc]);
                    chk("abort_din", dut_in_v[k], vecs[imin(n - 1, (kill_cyc - 2) / (s + 1))]);
                end
            end else begin
                chk("busy", busy_v[k], (cyc < done_cyc));
                chk("done", done_v[k], (cyc == done_cyc));
                if (cyc >= 2) begin
                    c = imin(n, (cyc - 2) / (s + 1));
                    chk("pattern_cnt", cnt_v[k], c);
                    chk("signature", sig_v[k], sigs[c]);
                    chk("dut_in", dut_in_v[k], vecs[imin(n - 1, (cyc - 2) / (s + 1))]);
                end
                if (cyc >= 2 && cyc < done_cyc) chk("pass_cleared", pass_v[k], 0);
                if (cyc > done_cyc) chk("pass_final", pass_v[k], (gold == sigs[n]));
            end
        end
        start_v[k] = 1'b0;
        abort_v[k] = 1'b0;
        rst_n      = 1'b1;
        chk("done_pulses", done_cnt, (kill_kind == 0) ? 1 : 0);

        if (kill_kind == 2) begin
            for (int j = 0; j < 2; j++) begin
                exp_cnt_v[j]  = 16'd0;
                exp_pass_v[j] = 1'b0;
            end
        end else if (kill_kind == 1) begin
            exp_cnt_v[k]  = 16'(kc);
            exp_pass_v[k] = 1'b0;
        end else begin
            exp_cnt_v[k]  = 16'(n);
            exp_pass_v[k] = (gold == sigs[n]);
        end
    endtask

    // start and abort together while idle: nothing may happen.
    task automatic idle_abort(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        abort_v[k] = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[k] = 1'b0;
            abort_v[k] = 1'b0;
            chk("idle_abort_busy", busy_v[k], 0);
            chk("idle_abort_done", done_v[k], 0);
            chk("idle_abort_cnt", cnt_v[k], exp_cnt_v[k]);
            chk("idle_abort_pass", pass_v[k], exp_pass_v[k]);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          k;
        int          mode;
        logic [16:0] mask;
        int          gmode;
        logic [16:0] gval;
        int          kill_cyc;
        int          kill_kind;
        int          restart_cyc;
        logic [15:0] exp_cnt;
        logic        exp_pass;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 0, 17'h00000, 0, 17'h00000, 0, 0, 0, 16'd4,  1'b1}; // zero response, golden 0
        tbl[1] = '{0, 1, 17'h00000, 1, 17'h00000, 0, 0, 0, 16'd4,  1'b1}; // loop-back, model golden
        tbl[2] = '{0, 1, 17'h00000, 2, 17'h00000, 0, 0, 0, 16'd4,  1'b0}; // golden bit 0 flipped
        tbl[3] = '{0, 1, 17'h00000, 1, 17'h00000, 7, 1, 0, 16'd2,  1'b0}; // abort in CAPTURE of vector 2
        tbl[4] = '{0, 1, 17'h00000, 1, 17'h00000, 0, 0, 5, 16'd4,  1'b1}; // restart; start while busy
        tbl[5] = '{0, 2, 17'h1a5c3, 1, 17'h00000, 8, 2, 0, 16'd0,  1'b0}; // reset in APPLY of vector 3
        tbl[6] = '{0, 2, 17'h1a5c3, 1, 17'h00000, 0, 0, 10, 16'd4, 1'b1}; // rerun after reset, start in DONE
        tbl[7] = '{1, 1, 17'h00000, 1, 17'h00000, 0, 0, 20, 16'd40, 1'b1}; // taps exercised
        tbl[8] = '{1, 2, 17'h0f0f1, 2, 17'h00000, 0, 0, 0, 16'd40, 1'b0};

        for (int j = 0; j < 2; j++) begin
            start_v[j]    = 1'b0;
            abort_v[j]    = 1'b0;
            golden_v[j]   = 17'd0;
            mode_v[j]     = 0;
            mask_v[j]     = 17'd0;
            exp_cnt_v[j]  = 16'd0;
            exp_pass_v[j] = 1'b0;
        end

        // Reset held 3 clocks with start asserted.
        rst_n      = 1'b0;
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_state", st_v[j], 0);
            chk("rst_dut_in", dut_in_v[j], 0);
            chk("rst_signature", sig_v[j], 0);
            chk("rst_pattern_cnt", cnt_v[j], 0);
            chk("rst_busy", busy_v[j], 0);
            chk("rst_done", done_v[j], 0);
            chk("rst_pass", pass_v[j], 0);
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy_v[0], 0);
        chk("post_rst_state", st_v[0], 0);

        for (int t = 0; t < 9; t++) begin
            mode_v[tbl[t].k] = tbl[t].mode;
            mask_v[tbl[t].k] = tbl[t].mask;
            run(tbl[t].k, tbl[t].gmode, tbl[t].gval, tbl[t].kill_cyc,
                tbl[t].kill_kind, tbl[t].restart_cyc);
            chk("tbl_cnt", cnt_v[tbl[t].k], tbl[t].exp_cnt);
            chk("tbl_pass", pass_v[tbl[t].k], tbl[t].exp_pass);
            if (t == 2 || t == 7) idle_abort(tbl[t].k);
        end

        // ---------------- randomized runs ----------------
        for (int r = 0; r < 14; r++) begin
            int k, kk, kc, rc, dc;
            k  = $urandom_range(0, 1);
            mode_v[k] = $urandom_range(1, 2);
            mask_v[k] = 17'($urandom);
            dc = 2 + n_of(k) * (s_of(k) + 1);
            kk = $urandom_range(0, 2);
            kc = $urandom_range(2, dc - 1);
            rc = 0;
            if ($urandom_range(0, 1) == 1)
                rc = (kk != 0) ? $urandom_range(2, kc) : $urandom_range(2, dc);
            run(k, $urandom_range(0, 2), 17'($urandom), kc, kk, rc);
            if (r % 5 == 4) idle_abort(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
